mips_hazard_unit: RTL

- Hazard detection and stall/flush controller for the 5-stage MIPS pipeline.
- It is the ID-side counterpart of the EX-stage forwarding unit. It resolves the cases forwarding cannot cover:
  - load-use hazards;
  - branch operands compared in ID;
  - multi-cycle multiply/divide occupancy.
- Its stall and flush outputs drive the PC register, the IF/ID register and the ID/EX register.
- It also supplies ID-stage forwarding selects from MEM for the branch comparator, and keeps a stall-cycle performance counter.

---
 rtl/mips_hazard_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mips_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_hazard_unit
// Brief    : ID-stage hazard detection, stall/flush control, branch-operand
//            forwarding selects, mult/div occupancy and stall-cycle counter.
// Revision : 1.0
// ============================================================================
module mips_hazard_unit #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RsID,
    input  logic [4:0]       RtID,
    input  logic             UsesRtID,
    input  logic             BranchID,
    input  logic             BranchTakenID,
    input  logic             MdStartID,
    input  logic             MdUseID,
    input  logic             RegWriteEX,
    input  logic             MemtoRegEX,
    input  logic [4:0]       WriteRegEX,
    input  logic             RegWriteMEM,
    input  logic             MemtoRegMEM,
    input  logic [4:0]       WriteRegMEM,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdState_t;

    localparam logic [3:0] c_MD_LOAD = 4'(MD_LATENCY - 1);

    mdState_t         r_mdState;
    logic [3:0]       r_mdCnt;
    logic             r_mdBusy;
    logic [CNT_W-1:0] r_stallCount;

    logic w_exDestNz;
    logic w_memDestNz;
    logic w_exHitRs;
    logic w_exHitRt;
    logic w_memHitRs;
    logic w_memHitRt;
    logic w_lwStall;
    logic w_branchStall;
    logic w_mdStall;
    logic w_stall;

    // $0 is hardwired, so a zero destination never matches anything.
    assign w_exDestNz  = (WriteRegEX  != 5'd0);
    assign w_memDestNz = (WriteRegMEM != 5'd0);
    assign w_exHitRs   = w_exDestNz  && (WriteRegEX  == RsID);
    assign w_exHitRt   = w_exDestNz  && (WriteRegEX  == RtID);
    assign w_memHitRs  = w_memDestNz && (WriteRegMEM == RsID);
    assign w_memHitRt  = w_memDestNz && (WriteRegMEM == RtID);

    assign w_lwStall     = MemtoRegEX && (w_exHitRs || (UsesRtID && w_exHitRt));
    assign w_branchStall = BranchID &&
                           ((RegWriteEX  && (w_exHitRs  || w_exHitRt)) ||
                            (MemtoRegMEM && (w_memHitRs || w_memHitRt)));
    assign w_mdStall     = r_mdBusy && MdUseID;
    assign w_stall       = w_lwStall || w_branchStall || w_mdStall;

    assign StallF = w_stall && !reset;
    assign StallD = w_stall && !reset;
    assign FlushE = w_stall && !reset;
    // A stalled branch waits for valid operands before squashing the fetch.
    assign FlushD = BranchTakenID && !w_stall && !reset;

    assign ForwardAD = RegWriteMEM && !MemtoRegMEM && w_memHitRs;
    assign ForwardBD = RegWriteMEM && !MemtoRegMEM && w_memHitRt;

    assign MdBusy     = r_mdBusy;
    assign StallCount = r_stallCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mdState    <= S_IDLE;
            r_mdCnt      <= 4'd0;
            r_mdBusy     <= 1'b0;
            r_stallCount <= '0;
        end else begin
            if (w_stall && (r_stallCount != '1)) begin
                r_stallCount <= r_stallCount + CNT_W'(1);
            end
            case (r_mdState)
                S_IDLE: begin
                    // A start held in ID by another hazard has not issued yet.
                    if (MdStartID && !w_stall) begin
                        r_mdState <= S_BUSY;
                        r_mdCnt   <= c_MD_LOAD;
                        r_mdBusy  <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (r_mdCnt == 4'd0) begin
                        r_mdState <= S_IDLE;
                        r_mdBusy  <= 1'b0;
                    end else begin
                        r_mdCnt <= r_mdCnt - 4'd1;
                    end
                end
                default: begin
                    r_mdState <= S_IDLE;
                    r_mdBusy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
